float_le_responder: RTL and testbench
=====================================

# float_le_responder

Sequential responder that serves "is A less than or equal to B" requests for IEEE-754 values of width FLEN. It is the comparator side of the compare interface used by the float-sorting FSMs. It adds a valid/ready handshake and a fixed two-stage evaluation: exponent first, then mantissa, so no full-width magnitude compare sits on one path. NaN and Inf operands are flagged as errors, matching the error rule the sorting blocks use.

## Interface
- FLEN, 64: operand width; legal values 16, 32, 64, 128.
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE and only while rst is low.
- req_a  in  FLEN  operand A; sampled only at the accepting edge.
- req_b  in  FLEN  operand B; sampled only at the accepting edge.
- res_valid  out  1  one-cycle result strobe.
- res_le  out  1  A <= B; holds until the next result.
- res_err  out  1  either operand has an all-ones exponent; holds until the next result.
- busy  out  1  state is not IDLE.

## Operation
- Widths:
  - NE is the exponent width: 5, 8, 11 or 15 for FLEN 16, 32, 64, 128.
  - NM = FLEN-1-NE is the mantissa width.
  - A field is sign, then exponent, then mantissa, MSB first.
- Accept: on an edge where req_valid and req_ready are both high, capture A and B and go IDLE→EXP.
- EXP state, registered at the edge:
  - err = A or B has exponent all ones; this covers both Inf and NaN.
  - zz = both operands have exponent and mantissa equal to zero, sign ignored.
  - sign relation of A and B.
  - exp_cmp: less, equal or greater, on the unsigned exponent fields.
  - Next state: MANT.
- MANT state: compute mant_cmp on the unsigned mantissa fields, then resolve in this priority order:
  1. err → res_le=0, res_err=1.
  2. zz → res_le=1, so +0 and −0 compare equal.
  3. Signs differ → res_le = sign(A).
  4. Both positive → res_le = |A| <= |B|.
  5. Both negative → res_le = |A| >= |B|.
- |A| vs |B| uses exp_cmp first; mant_cmp decides only when the exponents are equal.
- At the MANT edge, register res_le and res_err, set res_valid=1, and go MANT→IDLE.
- Resolution happens only in MANT, even when the exponents already decide the result. Latency is always fixed.
- Subnormals need no special case; the unsigned field compare already orders them correctly.

## Timing
- Reset values: state IDLE, res_valid 0, res_le 0, res_err 0, busy 0. req_ready is 0 while rst is high.
- Latency: res_valid is high in the cycle after the second edge following the accepting edge. This is 3 cycles from the request cycle to the result cycle.
- res_valid lasts exactly one cycle. res_le and res_err keep their value until the next res_valid.
- Throughput: one request per 3 cycles. A new request may be accepted in the same cycle res_valid is high, because state is already IDLE.
- req_valid while busy: ignored; the requester must hold it until ready.
- Input changes after acceptance have no effect.
- Reset mid-operation (in EXP or MANT):
  - Abort; no res_valid is produced.
  - All outputs return to their reset values at the next edge.
- rst high together with req_valid: no accept.

## Structure
- Package float_cmp_pkg:
  - function ne_of(FLEN) returning NE.
  - enum cmp_t {LT, EQ, GT} for exponent and mantissa comparisons.
  - enum state_t {IDLE, EXP, MANT}.
- Natural sub-module: float_field_classify, combinational.
  - Takes one operand; returns sign, exponent, mantissa, is_zero and is_err.
  - Instantiated twice, once for A and once for B.
- Everything else stays in one always_ff and one always_comb in the top module.

## Test plan
All values below are FLEN=64 hex encodings.
- A=3FF0000000000000 (1.0), B=4000000000000000 (2.0) → res_valid 3 cycles after request; res_le=1, res_err=0. Swap operands → res_le=0.
- A=3FF8000000000000 (1.5), B=3FF0000000000000 (1.0), equal exponents → res_le=0. A=B=3FF8000000000000 → res_le=1.
- A=BFF0000000000000 (−1.0), B=4000000000000000 → res_le=1. A=C000000000000000 (−2.0), B=BFF0000000000000 (−1.0) → res_le=1. Swap the two negatives → res_le=0.
- A=8000000000000000 (−0), B=0000000000000000 (+0) → res_le=1. Swap operands → res_le=1.
- A=7FF8000000000000 (NaN), B=0 → res_err=1, res_le=0. A=3FF0000000000000, B=7FF0000000000000 (+Inf) → res_err=1.
- Back-to-back:
  - Hold req_valid high continuously → accepts occur every 3 cycles, and each res_valid cycle coincides with the next accept.
  - Assert rst in the EXP state → no res_valid; outputs are zero after the edge.

Source files
------------

// File: rtl/float_cmp_pkg.sv
// Shared types and width helpers for the floating-point compare responder.
// Exponent/mantissa widths are derived from the IEEE-754 interchange formats.
package float_cmp_pkg;

  typedef enum logic [1:0] {LT, EQ, GT} cmp_t;

  typedef enum logic [1:0] {IDLE, EXP, MANT} state_t;

  function automatic int ne_of(input int flen);
    case (flen)
      16:      return 5;
      32:      return 8;
      64:      return 11;
      128:     return 15;
      default: return 11;
    endcase
  endfunction

endpackage

// File: rtl/float_field_classify.sv
// Splits one IEEE-754 operand into sign/exponent/mantissa and flags
// zero (sign ignored) and all-ones exponent (Inf or NaN).
module float_field_classify
  import float_cmp_pkg::*;
#(
  parameter  int FLEN = 64,
  localparam int NE   = ne_of(FLEN),
  localparam int NM   = FLEN - 1 - NE
) (
  input  logic [FLEN-1:0] op,
  output logic            sign,
  output logic [NE-1:0]   exp_f,
  output logic [NM-1:0]   mant_f,
  output logic            is_zero,
  output logic            is_err
);

  assign sign    = op[FLEN-1];
  assign exp_f   = op[FLEN-2 -: NE];
  assign mant_f  = op[NM-1:0];
  assign is_zero = (exp_f == '0) && (mant_f == '0);
  assign is_err  = &exp_f;

endmodule

// File: rtl/float_le_responder.sv
// Two-stage "A <= B" responder: exponent relation is registered in EXP,
// the mantissa relation and final resolution happen in MANT.
module float_le_responder
  import float_cmp_pkg::*;
#(
  parameter int FLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [FLEN-1:0] req_a,
  input  logic [FLEN-1:0] req_b,
  output logic            res_valid,
  output logic            res_le,
  output logic            res_err,
  output logic            busy
);

  localparam int NE = ne_of(FLEN);
  localparam int NM = FLEN - 1 - NE;

  state_t          state_q, state_d;
  logic [FLEN-1:0] a_q, a_d, b_q, b_d;
  logic            err_q, err_d, zz_q, zz_d;
  logic            sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  cmp_t            exp_cmp_q, exp_cmp_d;
  logic            res_valid_q, res_valid_d;
  logic            res_le_q, res_le_d;
  logic            res_err_q, res_err_d;

  logic            a_sign, b_sign, a_zero, b_zero, a_err, b_err;
  logic [NE-1:0]   a_exp, b_exp;
  logic [NM-1:0]   a_mant, b_mant;
  cmp_t            mant_cmp, mag_cmp;

  float_field_classify #(.FLEN(FLEN)) u_cls_a (
    .op(a_q), .sign(a_sign), .exp_f(a_exp), .mant_f(a_mant),
    .is_zero(a_zero), .is_err(a_err)
  );

  float_field_classify #(.FLEN(FLEN)) u_cls_b (
    .op(b_q), .sign(b_sign), .exp_f(b_exp), .mant_f(b_mant),
    .is_zero(b_zero), .is_err(b_err)
  );

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    err_d       = err_q;
    zz_d        = zz_q;
    sign_a_d    = sign_a_q;
    sign_b_d    = sign_b_q;
    exp_cmp_d   = exp_cmp_q;
    res_valid_d = 1'b0;
    res_le_d    = res_le_q;
    res_err_d   = res_err_q;

    mant_cmp = (a_mant < b_mant) ? LT : ((a_mant == b_mant) ? EQ : GT);
    // Mantissa only breaks a tie once the exponents are known equal.
    mag_cmp  = (exp_cmp_q == EQ) ? mant_cmp : exp_cmp_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          a_d     = req_a;
          b_d     = req_b;
          state_d = EXP;
        end
      end
      EXP: begin
        err_d     = a_err | b_err;
        zz_d      = a_zero & b_zero;
        sign_a_d  = a_sign;
        sign_b_d  = b_sign;
        exp_cmp_d = (a_exp < b_exp) ? LT : ((a_exp == b_exp) ? EQ : GT);
        state_d   = MANT;
      end
      MANT: begin
        res_valid_d = 1'b1;
        res_err_d   = err_q;
        if (err_q) begin
          res_le_d = 1'b0;
        end else if (zz_q) begin
          res_le_d = 1'b1;
        end else if (sign_a_q != sign_b_q) begin
          res_le_d = sign_a_q;
        end else if (!sign_a_q) begin
          res_le_d = (mag_cmp != GT);
        end else begin
          res_le_d = (mag_cmp != LT);
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      err_q       <= 1'b0;
      zz_q        <= 1'b0;
      sign_a_q    <= 1'b0;
      sign_b_q    <= 1'b0;
      exp_cmp_q   <= EQ;
      res_valid_q <= 1'b0;
      res_le_q    <= 1'b0;
      res_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      err_q       <= err_d;
      zz_q        <= zz_d;
      sign_a_q    <= sign_a_d;
      sign_b_q    <= sign_b_d;
      exp_cmp_q   <= exp_cmp_d;
      res_valid_q <= res_valid_d;
      res_le_q    <= res_le_d;
      res_err_q   <= res_err_d;
    end
  end

  assign req_ready = (state_q == IDLE) && !rst;
  assign busy      = (state_q != IDLE);
  assign res_valid = res_valid_q;
  assign res_le    = res_le_q;
  assign res_err   = res_err_q;

endmodule

// File: tb/tb_float_le_responder.sv
// Self-checking bench for float_le_responder (FLEN=64): directed cases,
// randomized operands against a real-arithmetic reference, back-to-back and reset abort.
module tb_float_le_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_a, req_b;
  logic        res_valid, res_le, res_err, busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  float_le_responder #(.FLEN(64)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .res_valid(res_valid), .res_le(res_le),
    .res_err(res_err), .busy(busy)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Reference: any all-ones exponent is an error, otherwise real-valued <=.
  function automatic void ref_le(input logic [63:0] a, input logic [63:0] b,
                                 output logic le, output logic err);
    err = (a[62:52] == 11'h7FF) || (b[62:52] == 11'h7FF);
    le  = err ? 1'b0 : ($bitstoreal(a) <= $bitstoreal(b));
  endfunction

  function automatic logic [63:0] rand_fp();
    logic [63:0] v;
    v = {$urandom, $urandom};
    case ($urandom_range(0, 7))
      0:       v[62:0]  = '0;
      1:       v[62:52] = 11'h7FF;
      2:       v[62:52] = '0;
      default: v[62:52] = 11'(1020 + $urandom_range(0, 8));
    endcase
    return v;
  endfunction

  task automatic run_one(input logic [63:0] a, input logic [63:0] b, input string tag);
    logic le_e, err_e;
    int   waited, lat;
    ref_le(a, b, le_e, err_e);
    waited = 0;
    while (!req_ready && waited < 10) begin
      @(posedge clk); #1;
      waited++;
    end
    check_eq({tag, "_ready"}, req_ready, 1);
    req_valid = 1'b1;
    req_a     = a;
    req_b     = b;
    @(posedge clk); #1;
    // Garbage on the request bus while busy must be ignored.
    req_a = {$urandom, $urandom};
    req_b = ~b;
    check_eq({tag, "_busy"}, busy, 1);
    lat = 1;
    while (!res_valid && lat < 8) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 2) req_valid = 1'b0;
    end
    req_valid = 1'b0;
    check_eq({tag, "_latency"}, lat, 3);
    check_eq({tag, "_le"}, res_le, le_e);
    check_eq({tag, "_err"}, res_err, err_e);
    $display("txn %s a=%h b=%h le=%0b err=%0b lat=%0d", tag, a, b, res_le, res_err, lat);
    @(posedge clk); #1;
    check_eq({tag, "_strobe_drop"}, res_valid, 0);
    check_eq({tag, "_le_hold"}, res_le, le_e);
  endtask

  initial begin
    logic [63:0] da[$], db[$], pa[6], pb[6];
    logic        le_q[$], err_q[$];
    logic        le_e, err_e, acc;
    int          idx, cycle, last_acc, results, seen;
    logic [63:0] a, b;

    rst = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_res_valid", res_valid, 0);
    check_eq("reset_res_le", res_le, 0);
    check_eq("reset_res_err", res_err, 0);
    check_eq("reset_busy", busy, 0);
    check_eq("reset_ready_low", req_ready, 0);
    rst = 1'b0;
    #1;
    check_eq("post_reset_ready", req_ready, 1);

    da = '{64'h3FF0000000000000, 64'h4000000000000000, 64'h3FF8000000000000,
           64'h3FF8000000000000, 64'hBFF0000000000000, 64'hC000000000000000,
           64'hBFF0000000000000, 64'h8000000000000000, 64'h0000000000000000,
           64'h7FF8000000000000, 64'h3FF0000000000000, 64'h0000000000000001,
           64'h000FFFFFFFFFFFFF};
    db = '{64'h4000000000000000, 64'h3FF0000000000000, 64'h3FF0000000000000,
           64'h3FF8000000000000, 64'h4000000000000000, 64'hBFF0000000000000,
           64'hC000000000000000, 64'h0000000000000000, 64'h8000000000000000,
           64'h0000000000000000, 64'h7FF0000000000000, 64'h0010000000000000,
           64'h0000000000000002};
    for (int i = 0; i < da.size(); i++) run_one(da[i], db[i], $sformatf("dir%0d", i));

    for (int i = 0; i < 150; i++) begin
      a = rand_fp();
      case ($urandom_range(0, 4))
        0:       b = a;
        1:       b = {~a[63], a[62:0]};
        2:       b = {a[63], a[62:52], $urandom_range(0, 1) ? a[51:0] + 52'd1 : {$urandom, $urandom} >> 12};
        default: b = rand_fp();
      endcase
      run_one(a, b, $sformatf("rnd%0d", i));
    end

    // Back-to-back with req_valid held high.
    for (int i = 0; i < 6; i++) begin
      pa[i] = rand_fp();
      pb[i] = (i % 2 == 0) ? {pa[i][63], pa[i][62:52], ~pa[i][51:0]} : rand_fp();
    end
    idx = 0; cycle = 0; last_acc = -1; results = 0;
    req_valid = 1'b1; req_a = pa[0]; req_b = pb[0];
    while (results < 6 && cycle < 60) begin
      acc = req_valid && req_ready;
      @(posedge clk); #1;
      cycle++;
      if (res_valid) begin
        if (le_q.size() == 0) begin
          check_eq("b2b_unexpected_result", 1, 0);
        end else begin
          le_e = le_q.pop_front();
          err_e = err_q.pop_front();
          check_eq("b2b_le", res_le, le_e);
          check_eq("b2b_err", res_err, err_e);
          check_eq("b2b_ready_on_result", req_ready, 1);
          $display("txn b2b%0d le=%0b err=%0b cycle=%0d", results, res_le, res_err, cycle);
        end
        results++;
      end
      if (acc) begin
        if (last_acc >= 0) check_eq("b2b_accept_spacing", cycle - last_acc, 3);
        last_acc = cycle;
        ref_le(pa[idx], pb[idx], le_e, err_e);
        le_q.push_back(le_e);
        err_q.push_back(err_e);
        idx++;
        if (idx < 6) begin
          req_a = pa[idx]; req_b = pb[idx];
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    req_valid = 1'b0;
    check_eq("b2b_result_count", results, 6);

    // Reset while in EXP: abort, outputs cleared, no result afterwards.
    run_one(64'h3FF0000000000000, 64'h4000000000000000, "pre_abort");
    req_valid = 1'b1; req_a = 64'hBFF0000000000000; req_b = 64'h4000000000000000;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_eq("abort_ready_in_rst", req_ready, 0);
    @(posedge clk); #1;
    check_eq("abort_busy", busy, 0);
    check_eq("abort_res_valid", res_valid, 0);
    check_eq("abort_res_le", res_le, 0);
    check_eq("abort_res_err", res_err, 0);
    req_valid = 1'b1;
    @(posedge clk); #1;
    check_eq("rst_with_valid_no_accept", busy, 0);
    rst = 1'b0; req_valid = 1'b0;
    seen = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (res_valid) seen++;
    end
    check_eq("abort_no_result", seen, 0);
    $display("txn abort res_valid_seen=%0d busy=%0b", seen, busy);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
